// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Sequences the MAR/MDR/DRAM datapath for an instruction-fetch
//               port (read only) and a data port (read/write). Round-robin
//               arbitration, fixed ADDR/WAIT/ACCESS/DONE cycle sequence and a
//               one-cycle acknowledge carrying the read data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 9,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mar_write,
  output logic [ADDR_W-1:0] mar_din,
  output logic              mdr_write,
  output logic              mdr_src,
  output logic [DATA_W-1:0] mdr_din,
  input  logic [DATA_W-1:0] mdr_dout,
  output logic              dram_write,
  output logic              busy,
  output logic [1:0]        gnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WAIT   = 3'd2,
    ACCESS = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              last_data;  // 1 when the data port won the last grant
  logic              own_data;   // owner of the current transaction
  logic              we_l;       // latched write flag (always 0 for fetch)
  logic [DATA_W-1:0] f_hold;
  logic [DATA_W-1:0] d_hold;
  logic              pick_data;

  // Arbitration choice: data wins when alone, or on a tie when fetch went last
  assign pick_data = d_req && (!f_req || !last_data);

  // Main sequencer; every datapath strobe is a registered output of this FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_data  <= 1'b1;
      own_data   <= 1'b0;
      we_l       <= 1'b0;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      f_hold     <= '0;
      d_hold     <= '0;
      mar_write  <= 1'b0;
      mar_din    <= '0;
      mdr_write  <= 1'b0;
      mdr_src    <= 1'b0;
      mdr_din    <= '0;
      dram_write <= 1'b0;
      busy       <= 1'b0;
      gnt        <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (f_req || d_req) begin
            state     <= ADDR;
            busy      <= 1'b1;
            own_data  <= pick_data;
            last_data <= pick_data;
            gnt       <= pick_data ? 2'b10 : 2'b01;
            we_l      <= pick_data & d_we;
            mar_write <= 1'b1;
            mar_din   <= pick_data ? d_addr : f_addr;
            mdr_write <= pick_data & d_we;
            mdr_src   <= pick_data & d_we;
            if (pick_data) begin
              mdr_din <= d_wdata;
            end
          end
        end
        ADDR: begin
          mar_write <= 1'b0;
          mdr_write <= 1'b0;
          mdr_src   <= 1'b0;
          cnt       <= 4'(WAIT_CYC);
          state     <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // <=1 rather than ==1 so an out-of-range WAIT_CYC of 0 cannot stall
          if (cnt <= 4'd1) begin
            state      <= ACCESS;
            mdr_write  <= ~we_l;
            dram_write <= we_l;
          end
        end
        ACCESS: begin
          mdr_write  <= 1'b0;
          dram_write <= 1'b0;
          f_ack      <= ~own_data;
          d_ack      <= own_data;
          state      <= DONE;
        end
        DONE: begin
          f_ack <= 1'b0;
          d_ack <= 1'b0;
          busy  <= 1'b0;
          gnt   <= 2'b00;
          state <= IDLE;
          if (!we_l) begin
            if (own_data) begin
              d_hold <= mdr_dout;
            end else begin
              f_hold <= mdr_dout;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is live MDR output during the completing read, else the hold copy
  assign f_rdata = (f_ack && !we_l) ? mdr_dout : f_hold;
  assign d_rdata = (d_ack && !we_l) ? mdr_dout : d_hold;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl with a MAR/MDR/DRAM
//               environment model and an ack scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int AW = 18;
  localparam int DW = 9;
  localparam int WC = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] f_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          f_ack, d_ack, mar_write, mdr_write, mdr_src, dram_write, busy;
  logic [DW-1:0] f_rdata, d_rdata, mdr_din;
  logic [AW-1:0] mar_din;
  logic [1:0]    gnt;
  logic [DW-1:0] mdr_q;

  // second instance, WAIT_CYC=4, with a fixed MDR value
  logic          b_f_req = 1'b0;
  logic [AW-1:0] b_f_addr = '0;
  logic [DW-1:0] b_mdr_dout = 9'h133;
  logic          b_f_ack, b_d_ack, b_mar_write, b_mdr_write, b_mdr_src, b_dram_write, b_busy;
  logic [DW-1:0] b_f_rdata, b_d_rdata, b_mdr_din;
  logic [AW-1:0] b_mar_din;
  logic [1:0]    b_gnt;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mar_write(mar_write), .mar_din(mar_din), .mdr_write(mdr_write),
    .mdr_src(mdr_src), .mdr_din(mdr_din), .mdr_dout(mdr_q),
    .dram_write(dram_write), .busy(busy), .gnt(gnt)
  );

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .f_req(b_f_req), .f_addr(b_f_addr), .f_ack(b_f_ack), .f_rdata(b_f_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .mar_write(b_mar_write), .mar_din(b_mar_din), .mdr_write(b_mdr_write),
    .mdr_src(b_mdr_src), .mdr_din(b_mdr_din), .mdr_dout(b_mdr_dout),
    .dram_write(b_dram_write), .busy(b_busy), .gnt(b_gnt)
  );

  always #5 clk = ~clk;

  // Environment: MAR, MDR with source mux, DRAM (async read of MAR)
  logic [AW-1:0] mar_q;
  logic [DW-1:0] dram [0:255];
  always @(posedge clk) begin
    if (mar_write) mar_q <= mar_din;
    if (mdr_write) mdr_q <= mdr_src ? mdr_din : dram[mar_q[7:0]];
    if (dram_write) dram[mar_q[7:0]] <= mdr_q;
  end

  // Reference memory maintained from the bench's own stimulus
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] f_hold_m, d_hold_m;

  typedef struct {
    bit            port;   // 0=fetch, 1=data
    bit            we;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ack pops one expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (f_ack && d_ack) check("dual_ack", 1, 0);
      if (busy) check("gnt_onehot", $countones(gnt), 1);
      if (f_ack || d_ack) begin
        if (sbq.size() == 0) begin
          check("unexpected_ack", {f_ack, d_ack}, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("ack_port", d_ack, mon_e.port);
          if (mon_e.we) begin
            check("write_keeps_d_rdata", d_rdata, d_hold_m);
          end else if (mon_e.port) begin
            check("d_rdata", d_rdata, mon_e.rdata);
            d_hold_m = mon_e.rdata;
          end else begin
            check("f_rdata", f_rdata, mon_e.rdata);
            f_hold_m = mon_e.rdata;
          end
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_acks"}, {f_ack, d_ack}, 0);
    check({tag, "_rdata"}, {f_rdata, d_rdata}, 0);
    check({tag, "_strobes"}, {mar_write, mdr_write, dram_write, mdr_src}, 0);
    check({tag, "_mar_din"}, mar_din, 0);
    check({tag, "_mdr_din"}, mdr_din, 0);
    check({tag, "_b_busy"}, b_busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    f_req = 0; d_req = 0; b_f_req = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    f_hold_m = '0;
    d_hold_m = '0;
    sbq.delete();
  endtask

  // One full transaction with cycle-by-cycle strobe checks
  task automatic xact(input bit port, input bit we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [AW-1:0] alt_addr);
    exp_t it;
    @(negedge clk);
    if (port) begin
      d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1; f_addr = addr;
    end
    it.port  = port;
    it.we    = we;
    it.rdata = ref_mem[addr[7:0]];
    if (we) ref_mem[addr[7:0]] = wdata;
    sbq.push_back(it);
    @(posedge clk); #1;
    check("addr_mar_write", mar_write, 1);
    check("addr_mar_din", mar_din, addr);
    check("addr_mdr_write", mdr_write, we);
    check("addr_mdr_src", mdr_src, we);
    if (we) check("addr_mdr_din", mdr_din, wdata);
    check("addr_gnt", gnt, port ? 2 : 1);
    check("addr_busy", busy, 1);
    for (int i = 0; i < WC; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        if (port) d_addr = alt_addr; else f_addr = alt_addr;
      end
      check("wait_strobes", {mar_write, mdr_write, dram_write}, 0);
    end
    @(posedge clk); #1;
    check("acc_mdr_write", mdr_write, !we);
    check("acc_mdr_src", mdr_src, 0);
    check("acc_dram_write", dram_write, we);
    @(posedge clk); #1;
    check("done_ack", port ? d_ack : f_ack, 1);
    check("done_dram_write", dram_write, 0);
    f_req = 0; d_req = 0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_acks", {f_ack, d_ack}, 0);
  endtask

  int acks;
  exp_t e;

  initial begin
    for (int i = 0; i < 256; i++) begin
      dram[i]    = 9'(i * 7);
      ref_mem[i] = 9'(i * 7);
    end
    dram[3] = 9'h0A5; ref_mem[3] = 9'h0A5;
    dram[9] = 9'h011; ref_mem[9] = 9'h011;
    f_hold_m = '0; d_hold_m = '0;

    do_reset();

    // fetch read of addr 3
    xact(0, 0, 18'd3, 9'h0, 18'd3);
    check("f_rdata_hold", f_rdata, 9'h0A5);

    // data write then read back
    xact(1, 1, 18'd9, 9'h1FF, 18'd9);
    check("d_rdata_after_write", d_rdata, 9'h000);
    xact(1, 0, 18'd9, 9'h0, 18'd9);
    check("d_rdata_hold", d_rdata, 9'h1FF);

    // address change while busy must be ignored
    xact(1, 0, 18'd9, 9'h0, 18'd3);
    check("f_rdata_untouched", f_rdata, 9'h0A5);

    // reset during ACCESS of a write
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 18'd20; d_wdata = 9'h055;
    repeat (WC + 2) @(posedge clk);
    #1 check("pre_rst_dram_write", dram_write, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    d_req = 0; d_we = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    f_hold_m = '0; d_hold_m = '0;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 check("post_rst_idle", busy, 0);
    check("no_write_on_reset", dram[20], ref_mem[20]);

    // simultaneous held requests: fetch, data, fetch, data
    @(negedge clk);
    f_req = 1; f_addr = 18'd3;
    d_req = 1; d_we = 0; d_addr = 18'd9;
    for (int k = 0; k < 4; k++) begin
      e.port  = (k % 2) == 1;
      e.we    = 0;
      e.rdata = e.port ? ref_mem[9] : ref_mem[3];
      sbq.push_back(e);
    end
    acks = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      @(posedge clk); #1;
      if (f_ack || d_ack) begin
        acks++;
        if (acks == 4) begin
          f_req = 0; d_req = 0;
        end
      end
    end
    check("rr_ack_count", acks, 4);
    repeat (3) @(posedge clk);
    #1 check("rr_idle", busy, 0);
    check("sb_empty", sbq.size(), 0);

    // WAIT_CYC=4 instance: ack 7 cycles after the request edge
    @(negedge clk);
    b_f_req = 1; b_f_addr = 18'd5;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check("w4_busy", b_busy, k <= 7);
      check("w4_ack", b_f_ack, k == 7);
      if (k == 7) begin
        check("w4_rdata", b_f_rdata, 9'h133);
        b_f_req = 0;
      end
    end
    check("w4_rdata_hold", b_f_rdata, 9'h133);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller that sequences the MAR/MDR/DRAM datapath for two requesters: the instruction-fetch port (read only) and the data port (read/write). It arbitrates round-robin between the ports and drives MAR load, MDR load with source select, and the DRAM write strobe in a fixed cycle sequence. It returns a one-cycle acknowledge with read data. It sits between the processor control unit and the MAR, MDR and DRAM instances.

## Interface
Parameters:
- ADDR_W, 18, address width (matches MAR/DRAM)
- DATA_W, 9, data width (matches MDR/DRAM)
- WAIT_CYC, 1, DRAM access wait cycles between MAR load and access; legal range 1..15

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- f_req  in  1  fetch request; level, held until f_ack
- f_addr  in  ADDR_W  fetch address, stable while f_req=1
- f_ack  out  1  one-cycle pulse: fetch complete
- f_rdata  out  DATA_W  fetch read data
- d_req  in  1  data-port request; level, held until d_ack
- d_we  in  1  1=write, 0=read; stable while d_req=1
- d_addr  in  ADDR_W  data-port address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  data-port read data
- mar_write  out  1  MAR load enable
- mar_din  out  ADDR_W  MAR input
- mdr_write  out  1  MDR load enable
- mdr_src  out  1  MDR input mux select: 0=DRAM dout, 1=mdr_din
- mdr_din  out  DATA_W  write data toward MDR mux
- mdr_dout  in  DATA_W  MDR output
- dram_write  out  1  DRAM write strobe
- busy  out  1  1 in any state other than IDLE
- gnt  out  2  one-hot owner of the current transaction: bit0=fetch, bit1=data; 0 in IDLE

## Operation
- FSM states: IDLE, ADDR, WAIT, ACCESS, DONE. All outputs decode from registered state and latched request; no combinational path from req inputs to any output.
- IDLE:
  - Samples f_req and d_req.
  - If exactly one is high, grant it.
  - If both are high, grant the port not granted last. The last-grant flag resets to "data", so fetch wins the first tie.
  - On grant, latch addr, we (forced 0 for fetch), and wdata; update the last-grant flag; go to ADDR.
- ADDR:
  - mar_write=1, mar_din=latched addr.
  - Write only: mdr_write=1, mdr_src=1, mdr_din=latched wdata.
  - Load wait counter with WAIT_CYC; go to WAIT.
- WAIT: decrement counter each cycle; go to ACCESS in the cycle the counter reaches 1.
- ACCESS:
  - Read: mdr_write=1, mdr_src=0 (MDR captures DRAM dout).
  - Write: dram_write=1 for exactly this cycle.
  - Go to DONE.
- DONE:
  - Assert the owning port's ack for one cycle.
  - Read: that port's rdata = mdr_dout combinationally in this cycle, and its hold register loads mdr_dout at the closing edge.
  - Go to IDLE.
- rdata outside DONE: each port's rdata shows its hold register. The register changes only on that port's read completion; writes never change d_rdata.
- Re-request: a requester that keeps req high after its ack starts a new transaction, since IDLE samples req again.
- Idle defaults: mar_write, mdr_write, dram_write and mdr_src are 0 in every state where not listed above. mar_din and mdr_din keep their latched values.

## Timing
- Request sampled high at edge E0 (in IDLE): ADDR = E0..E1, WAIT occupies WAIT_CYC cycles, then ACCESS, then DONE.
- Ack is high in cycle WAIT_CYC+3 after E0 (4 for default WAIT_CYC=1).
- Throughput: one transaction per WAIT_CYC+4 cycles (IDLE cycle included).
- Reset values (async, immediate on rst_n=0):
  - state=IDLE, counter=0, last-grant=data.
  - f_ack=d_ack=0; f_rdata=d_rdata=0; mar_write=mdr_write=dram_write=mdr_src=0.
  - mar_din=0, mdr_din=0, busy=0, gnt=0.
- Reset mid-transaction: the transaction is discarded with no ack and no dram_write pulse after rst_n falls. The requester re-issues after reset.
- Changes to req, addr or data while busy are ignored; only IDLE samples inputs.

## Test plan
- Reset: rst_n=0 mid-ACCESS of a write -> dram_write drops immediately; all outputs at reset values; no ack; state IDLE after release.
- Fetch read, WAIT_CYC=1: DRAM preloaded addr 3 = 9'h0A5; f_req=1, f_addr=3 -> mar_write in cycle 1, mdr_write/mdr_src=0 in cycle 3, f_ack with f_rdata=9'h0A5 in cycle 4; f_rdata holds 9'h0A5 after.
- Data write then read back: d_we=1, d_addr=9, d_wdata=9'h1FF -> mdr_write/mdr_src=1 in ADDR, single dram_write pulse, d_ack. Then a read of addr 9 -> d_rdata=9'h1FF; d_rdata unchanged by the write itself.
- Simultaneous requests from reset: f_req=d_req=1 held -> grants alternate fetch, data, fetch, data with gnt one-hot; each ack fires once per grant.
- WAIT_CYC=4 fetch: ack exactly 7 cycles after the request edge; busy high for cycles 1..7.
- Input change while busy: alter d_addr from 9 to 3 during WAIT -> access still goes to addr 9.
